// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: round-robin arbiter for the register file write
// port, shared by the ALU writeback (A) and the load unit (B).
// It also keeps a pending-write scoreboard that decode uses for RAW checks.
// Ports:
//   in_a_*, in_b_*  : writeback requests (valid/rd/val)
//   out_*_ready     : grant for the current cycle
//   in_hold         : blocks all grants
//   in_rsv_*        : destination reservation
//   in_rs, in_rt    : hazard queries
//   out_*_busy      : busy bits for the queried sources
//   out_stall       : either queried source is busy
//   out_regwrt, out_rd, out_rdval : registered register file write
module regfile_write_scheduler #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int NREGS  = 64
) (
  input  logic              clk,
  input  logic              in_rst_n,
  input  logic              in_hold,
  input  logic              in_a_valid,
  input  logic [ADDR_W-1:0] in_a_rd,
  input  logic [DATA_W-1:0] in_a_val,
  output logic              out_a_ready,
  input  logic              in_b_valid,
  input  logic [ADDR_W-1:0] in_b_rd,
  input  logic [DATA_W-1:0] in_b_val,
  output logic              out_b_ready,
  input  logic              in_rsv_valid,
  input  logic [ADDR_W-1:0] in_rsv_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  output logic              out_rs_busy,
  output logic              out_rt_busy,
  output logic              out_stall,
  output logic              out_regwrt,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_rdval
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e             prio_q, prio_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              regwrt_q, regwrt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rdval_q, rdval_d;

  logic a_gnt;
  logic b_gnt;
  logic both;

  always_comb begin
    both  = in_a_valid & in_b_valid;
    a_gnt = ~in_hold & in_a_valid &
            (~in_b_valid | (prio_q == PRIO_A));
    b_gnt = ~in_hold & in_b_valid &
            (~in_a_valid | (prio_q == PRIO_B));
  end

  always_comb begin
    prio_d   = prio_q;
    busy_d   = busy_q;
    regwrt_d = 1'b0;
    rd_d     = rd_q;
    rdval_d  = rdval_q;

    // Pointer moves only on a contended grant, to the loser.
    if (both && (a_gnt || b_gnt)) begin
      prio_d = a_gnt ? PRIO_B : PRIO_A;
    end

    unique case (1'b1)
      a_gnt: begin
        regwrt_d = 1'b1;
        rd_d     = in_a_rd;
        rdval_d  = in_a_val;
      end
      b_gnt: begin
        regwrt_d = 1'b1;
        rd_d     = in_b_rd;
        rdval_d  = in_b_val;
      end
      default: ;
    endcase

    if (a_gnt || b_gnt) begin
      busy_d[rd_d] = 1'b0;
    end
    // Set after clear: a younger reservation wins.
    if (in_rsv_valid) begin
      busy_d[in_rsv_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      prio_q   <= PRIO_A;
      busy_q   <= '0;
      regwrt_q <= 1'b0;
      rd_q     <= '0;
      rdval_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      busy_q   <= busy_d;
      regwrt_q <= regwrt_d;
      rd_q     <= rd_d;
      rdval_q  <= rdval_d;
    end
  end

  assign out_a_ready = a_gnt;
  assign out_b_ready = b_gnt;
  assign out_rs_busy = busy_q[in_rs];
  assign out_rt_busy = busy_q[in_rt];
  assign out_stall   = out_rs_busy | out_rt_busy;
  assign out_regwrt  = regwrt_q;
  assign out_rd      = rd_q;
  assign out_rdval   = rdval_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        a_valid, b_valid;
  logic [5:0]  a_rd, b_rd;
  logic [31:0] a_val, b_val;
  logic        a_ready, b_ready;
  logic        rsv_valid;
  logic [5:0]  rsv_rd, rs, rt;
  logic        rs_busy, rt_busy, stall;
  logic        regwrt;
  logic [5:0]  rd;
  logic [31:0] rdval;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .clk          (clk),
    .in_rst_n     (rst_n),
    .in_hold      (hold),
    .in_a_valid   (a_valid),
    .in_a_rd      (a_rd),
    .in_a_val     (a_val),
    .out_a_ready  (a_ready),
    .in_b_valid   (b_valid),
    .in_b_rd      (b_rd),
    .in_b_val     (b_val),
    .out_b_ready  (b_ready),
    .in_rsv_valid (rsv_valid),
    .in_rsv_rd    (rsv_rd),
    .in_rs        (rs),
    .in_rt        (rt),
    .out_rs_busy  (rs_busy),
    .out_rt_busy  (rt_busy),
    .out_stall    (stall),
    .out_regwrt   (regwrt),
    .out_rd       (rd),
    .out_rdval    (rdval)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_out(input string tag,
                        input logic [5:0] erd,
                        input logic [31:0] eval);
    chk({tag, "_regwrt"}, {31'd0, regwrt}, 32'd1);
    chk({tag, "_rd"}, {26'd0, rd}, {26'd0, erd});
    chk({tag, "_rdval"}, rdval, eval);
  endtask

  task automatic rdy(input string tag,
                     input logic ea, input logic eb);
    chk({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
    chk({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, eb});
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_val = '0;
    b_valid = 1'b0; b_rd = '0; b_val = '0;
    rsv_valid = 1'b0; rsv_rd = '0;
    rs = 6'd0; rt = 6'd63;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_regwrt", {31'd0, regwrt}, 32'd0);
    chk("rst_rd", {26'd0, rd}, 32'd0);
    chk("rst_rdval", rdval, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rdy("rst_idle", 1'b0, 1'b0);

    // Single writer
    a_valid = 1'b1; a_rd = 6'd5; a_val = 32'h100;
    #1;
    rdy("single", 1'b1, 1'b0);
    tick();
    a_valid = 1'b0;
    #1;
    wr_out("single_wr", 6'd5, 32'h100);
    tick();
    chk("single_idle_regwrt", {31'd0, regwrt}, 32'd0);
    chk("single_hold_rd", {26'd0, rd}, 32'd5);

    // Contention, prio starts at A
    a_valid = 1'b1; a_rd = 6'd1; a_val = 32'h8;
    b_valid = 1'b1; b_rd = 6'd2; b_val = 32'h20;
    #1;
    rdy("cont1", 1'b1, 1'b0);
    tick();
    a_val = 32'h9;
    #1;
    wr_out("cont1_wr", 6'd1, 32'h8);
    rdy("cont2", 1'b0, 1'b1);
    tick();
    b_val = 32'h21;
    #1;
    wr_out("cont2_wr", 6'd2, 32'h20);
    rdy("cont3", 1'b1, 1'b0);
    tick();
    a_valid = 1'b0;
    #1;
    wr_out("cont3_wr", 6'd1, 32'h9);
    rdy("cont4", 1'b0, 1'b1);
    tick();
    b_valid = 1'b0;
    #1;
    wr_out("cont4_wr", 6'd2, 32'h21);

    // Hold with both valid; prio is B here
    hold = 1'b1;
    a_valid = 1'b1; a_rd = 6'd10; a_val = 32'hA0;
    b_valid = 1'b1; b_rd = 6'd11; b_val = 32'hB0;
    #1;
    for (int i = 0; i < 3; i++) begin
      rdy("hold", 1'b0, 1'b0);
      tick();
      chk("hold_regwrt", {31'd0, regwrt}, 32'd0);
    end
    hold = 1'b0;
    #1;
    rdy("hold_rel1", 1'b0, 1'b1);
    tick();
    b_valid = 1'b0;
    #1;
    wr_out("hold_rel1_wr", 6'd11, 32'hB0);
    rdy("hold_rel2", 1'b1, 1'b0);
    tick();
    a_valid = 1'b0;
    #1;
    wr_out("hold_rel2_wr", 6'd10, 32'hA0);
    tick();

    // Scoreboard RAW on r7
    rsv_valid = 1'b1; rsv_rd = 6'd7;
    tick();
    rsv_valid = 1'b0;
    rs = 6'd7; rt = 6'd0;
    #1;
    chk("raw_rs_busy", {31'd0, rs_busy}, 32'd1);
    chk("raw_rt_busy", {31'd0, rt_busy}, 32'd0);
    chk("raw_stall", {31'd0, stall}, 32'd1);
    b_valid = 1'b1; b_rd = 6'd7; b_val = 32'h77;
    #1;
    rdy("raw_xfer", 1'b0, 1'b1);
    chk("raw_stall_no_bypass", {31'd0, stall}, 32'd1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("raw_stall_released", {31'd0, stall}, 32'd0);
    wr_out("raw_wr", 6'd7, 32'h77);

    // Same-edge set and clear of r7: set wins
    rsv_valid = 1'b1; rsv_rd = 6'd7;
    b_valid = 1'b1; b_rd = 6'd7; b_val = 32'h78;
    tick();
    // Reserve r9 while r7 completes
    rsv_rd = 6'd9;
    b_rd = 6'd7; b_val = 32'h79;
    #1;
    chk("same_edge_busy7", {31'd0, rs_busy}, 32'd1);
    tick();
    rsv_valid = 1'b0; b_valid = 1'b0;
    rt = 6'd9;
    #1;
    chk("diff_busy7_clr", {31'd0, rs_busy}, 32'd0);
    chk("diff_busy9_set", {31'd0, rt_busy}, 32'd1);

    // r0 reservable; hold does not block reservations
    hold = 1'b1;
    rsv_valid = 1'b1; rsv_rd = 6'd0;
    tick();
    rsv_rd = 6'd3;
    rs = 6'd0;
    #1;
    chk("r0_busy", {31'd0, rs_busy}, 32'd1);
    tick();
    rsv_valid = 1'b0; hold = 1'b0;
    rs = 6'd3;
    #1;
    chk("hold_rsv_busy3", {31'd0, rs_busy}, 32'd1);

    // Move prio to B, then reset during an A transfer
    a_valid = 1'b1; a_rd = 6'd4; a_val = 32'h44;
    b_valid = 1'b1; b_rd = 6'd5; b_val = 32'h55;
    #1;
    rdy("pre_rst", 1'b1, 1'b0);
    tick();
    a_rd = 6'd3; a_val = 32'h33;
    b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    rdy("rst_xfer", 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("mid_rst_regwrt", {31'd0, regwrt}, 32'd0);
    chk("mid_rst_rd", {26'd0, rd}, 32'd0);
    chk("mid_rst_rdval", rdval, 32'd0);
    chk("mid_rst_busy3", {31'd0, rs_busy}, 32'd0);
    chk("mid_rst_busy9", {31'd0, rt_busy}, 32'd0);
    rdy("mid_rst_prio", 1'b1, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the single write port of the 64 x 32-bit register file between two writeback requesters:
  - A: the ALU/writeback stage.
  - B: the multi-cycle memory/load unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Keeps a 64-bit pending-write scoreboard so the decode stage can detect RAW hazards on rs/rt.
- Sits between the writeback sources and the register file's write-enable, rd and rdval inputs.

Parameters:
- ADDR_W, 6: register address width.
- DATA_W, 32: register data width.
- NREGS, 64: number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- in_rst_n  input  1  synchronous active-low reset.
- in_hold  input  1  freezes arbitration; no grants while high.
- in_a_valid  input  1  requester A has a write.
- in_a_rd  input  ADDR_W  requester A destination.
- in_a_val  input  DATA_W  requester A data.
- out_a_ready  output  1  requester A granted this cycle.
- in_b_valid  input  1  requester B has a write.
- in_b_rd  input  ADDR_W  requester B destination.
- in_b_val  input  DATA_W  requester B data.
- out_b_ready  output  1  requester B granted this cycle.
- in_rsv_valid  input  1  decode reserves a destination.
- in_rsv_rd  input  ADDR_W  register being reserved.
- in_rs  input  ADDR_W  hazard query, source 1.
- in_rt  input  ADDR_W  hazard query, source 2.
- out_rs_busy  output  1  busy[in_rs].
- out_rt_busy  output  1  busy[in_rt].
- out_stall  output  1  out_rs_busy | out_rt_busy.
- out_regwrt  output  1  register file write enable (registered).
- out_rd  output  ADDR_W  register file write address (registered).
- out_rdval  output  DATA_W  register file write data (registered).

Behaviour:
- Reset (in_rst_n=0 at a clk edge):
  - busy[63:0]=0, prio=A.
  - out_regwrt=0, out_rd=0, out_rdval=0.
  - A write accepted in the same cycle as reset is dropped.
- Grant logic (combinational from current inputs and prio):
  - in_hold=1: out_a_ready=out_b_ready=0.
  - Else only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the side named by prio.
  - At most one ready is high per cycle. Ready is never high without the matching valid.
- Handshake:
  - A transfer occurs when valid & ready at the rising edge.
  - Requester holds rd/val stable until its transfer occurs.
- Priority pointer:
  - Updates only when both were valid and a grant occurred; it then points to the non-granted side.
  - A single-requester grant leaves prio unchanged.
- Write latency is 1 cycle:
  - Transfer at edge N drives out_regwrt=1 with out_rd/out_rdval of the winner for cycle N..N+1.
  - The register file commits it at edge N+1.
  - No transfer: out_regwrt=0; out_rd/out_rdval hold their previous values.
- Throughput: one write per cycle; back-to-back transfers produce consecutive out_regwrt=1 cycles.
- Scoreboard:
  - in_rsv_valid at an edge sets busy[in_rsv_rd].
  - A transfer at an edge clears busy[winner rd].
  - Same register set and cleared at the same edge: set wins (a younger reservation overrides the completing older one).
  - Different registers: both take effect.
  - Clearing a non-busy register is legal and has no effect.
- Queries are combinational from current busy:
  - out_rs_busy=busy[in_rs], out_rt_busy=busy[in_rt].
  - There is no bypass of a same-cycle clear; the stall releases the cycle after the transfer.
- Register 0 is an ordinary register: reservable, writable, trackable.
- in_hold only blocks grants. Reservations and the scoreboard keep operating.

Test Plan:
- Reset then idle: in_rst_n low 2 cycles, then high -> out_regwrt=0, out_rd=0, out_rdval=0, out_stall=0 for any rs/rt.
- Single writer: A valid rd=5 val=0x100 for one cycle -> out_a_ready=1 that cycle; next cycle out_regwrt=1, out_rd=5, out_rdval=0x100; following cycle out_regwrt=0.
- Contention: A(rd=1,0x8) and B(rd=2,0x20) held valid from reset:
  - A granted first, B second.
  - out_regwrt high 2 consecutive cycles with rd=1 then rd=2.
  - Repeat with new data -> A granted first again (prio back at A).
- Hold: both valid, in_hold=1 for 3 cycles -> no ready, out_regwrt=0; release -> grants resume per prio.
- Scoreboard RAW:
  - Reserve rd=7; query rs=7 -> out_rs_busy=1, out_stall=1 until B transfers rd=7.
  - out_stall=0 the cycle after the transfer edge.
  - Same-edge reserve of 7 and transfer of 7 -> busy[7] stays 1.
- Reset mid-operation: A transfer at the same edge as in_rst_n=0 with busy[3]=1 -> out_regwrt=0 next cycle, busy cleared, prio=A.
